// File: rtl/sha_256_compression_core_if.sv
// Upstream-facing bundle of the SHA-256 compression core: block start, word stream and digest.
// Round-trace signals exist only when SHA_256_ROUND_TRACE_EN is defined.
interface sha_256_compression_core_if;
  logic         start;
  logic         first_block;
  logic         w_valid;
  logic [31:0]  w;
  logic         busy;
  logic         hash_valid;
  logic [255:0] hash_out;
`ifdef SHA_256_ROUND_TRACE_EN
  logic [6:0]   round_idx;
  logic         round_done;

  modport master (
    output start, first_block, w_valid, w,
    input  busy, hash_valid, hash_out, round_idx, round_done
  );
  modport slave (
    input  start, first_block, w_valid, w,
    output busy, hash_valid, hash_out, round_idx, round_done
  );
`else
  modport master (
    output start, first_block, w_valid, w,
    input  busy, hash_valid, hash_out
  );
  modport slave (
    input  start, first_block, w_valid, w,
    output busy, hash_valid, hash_out
  );
`endif
endinterface

// File: rtl/sha_256_compression_core.sv
// SHA-256 compression core: one round per accepted scheduled word, chaining value update in FINAL.
// Optional round trace outputs (round_idx, round_done) are enabled by defining SHA_256_ROUND_TRACE_EN.
module sha_256_compression_core #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  sha_256_compression_core_if.slave    bus
);

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_FINAL  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [6:0]    round_r;
  logic [31:0]   a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
  logic [255:0]  chain_r;
  logic [255:0]  hash_r;
  logic          busy_r;
  logic          hash_valid_r;

  logic          load_s;
  logic          consume_s;
  logic          final_s;
  logic          last_s;
  logic [31:0]   k_s;
  logic [31:0]   t1_s;
  logic [31:0]   t2_s;
  logic [255:0]  init_s;
  logic [255:0]  new_hash_s;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = 32'h00000000;
    endcase
    return k;
  endfunction

  assign last_s = (round_r == LAST_ROUND);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_ROUNDS;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ROUNDS: begin
        if (bus.w_valid && last_s) state_nxt_s = ST_FINAL;
        else                       state_nxt_s = ST_ROUNDS;
      end
      ST_FINAL: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes
  always_comb begin
    load_s    = 1'b0;
    consume_s = 1'b0;
    final_s   = 1'b0;
    case (state_r)
      ST_IDLE:   load_s    = bus.start;
      ST_ROUNDS: consume_s = bus.w_valid;
      ST_FINAL:  final_s   = 1'b1;
      default: begin
        load_s    = 1'b0;
        consume_s = 1'b0;
        final_s   = 1'b0;
      end
    endcase
  end

  // Round arithmetic and block-boundary values
  always_comb begin
    k_s  = k_rom(round_r[5:0]);
    t1_s = h_r + big_sigma1(e_r) + ch(e_r, f_r, g_r) + k_s + bus.w;
    t2_s = big_sigma0(a_r) + maj(a_r, b_r, c_r);
    new_hash_s = {chain_r[255:224] + a_r, chain_r[223:192] + b_r,
                  chain_r[191:160] + c_r, chain_r[159:128] + d_r,
                  chain_r[127:96]  + e_r, chain_r[95:64]   + f_r,
                  chain_r[63:32]   + g_r, chain_r[31:0]    + h_r};
    if (bus.first_block) init_s = IV;
    else                 init_s = chain_r;
  end

  // Working variables, chaining value, digest and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_r      <= 7'd0;
      {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r} <= 256'd0;
      chain_r      <= 256'd0;
      hash_r       <= 256'd0;
      busy_r       <= 1'b0;
      hash_valid_r <= 1'b0;
    end else begin
      busy_r       <= (state_nxt_s != ST_IDLE);
      hash_valid_r <= final_s;
      if (load_s) begin
        chain_r <= init_s;
        {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r} <= init_s;
        round_r <= 7'd0;
      end else if (consume_s) begin
        h_r <= g_r;
        g_r <= f_r;
        f_r <= e_r;
        e_r <= d_r + t1_s;
        d_r <= c_r;
        c_r <= b_r;
        b_r <= a_r;
        a_r <= t1_s + t2_s;
        round_r <= round_r + 7'd1;
      end else if (final_s) begin
        chain_r <= new_hash_s;
        hash_r  <= new_hash_s;
        round_r <= 7'd0;
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.hash_valid = hash_valid_r;
  assign bus.hash_out   = hash_r;

`ifdef SHA_256_ROUND_TRACE_EN
  logic round_done_r;

  // Pulse marking each consumed word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_done_r <= 1'b0;
    end else begin
      round_done_r <= consume_s;
    end
  end

  assign bus.round_idx  = round_r;
  assign bus.round_done = round_done_r;
`endif

endmodule

// File: tb/tb_sha_256_compression_core.sv
// Scoreboard bench for sha_256_compression_core: directed FIPS 180-4 vectors with known digests.
module tb_sha_256_compression_core;

  localparam int MODE_PLAIN  = 0;
  localparam int MODE_STALL  = 1;
  localparam int MODE_IGNORE = 2;
  localparam int MODE_ABORT  = 3;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    logic [255:0] digest;
    bit           check_digest;
    int           cycle;
  } exp_t;

  logic         clk;
  logic         rst;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  exp_t         exp_q[$];
  logic [31:0]  wsched [64];
  logic [255:0] prev_hash = 256'h0;

  sha_256_compression_core_if bus_if();

  sha_256_compression_core #(.NUM_ROUNDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule expansion (stands in for the upstream scheduler)
  task automatic expand(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) wsched[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(wsched[t-15], 7) ^ rotr(wsched[t-15], 18) ^ (wsched[t-15] >> 3);
      s1 = rotr(wsched[t-2], 17) ^ rotr(wsched[t-2], 19) ^ (wsched[t-2] >> 10);
      wsched[t] = s1 + wsched[t-7] + s0 + wsched[t-16];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic abort_block();
    rst = 1'b0;
    #2;
    chk("abort_busy", bus_if.busy, 1'b0);
    chk("abort_hash_valid", bus_if.hash_valid, 1'b0);
    chk("abort_hash_out", bus_if.hash_out, 256'h0);
`ifdef SHA_256_ROUND_TRACE_EN
    chk("abort_round_idx", bus_if.round_idx, 7'd0);
`endif
    bus_if.w_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
  endtask

  task automatic run_block(input logic [511:0] blk, input logic first, input logic [255:0] digest,
                           input bit check_digest, input int mode);
    exp_t e;
    bit   seen;
    expand(blk);
    if (mode == MODE_IGNORE) begin
      bus_if.w_valid = 1'b1;
      bus_if.w = 32'hdeadbeef;
      step();
      step();
`ifdef SHA_256_ROUND_TRACE_EN
      chk("trace_idle", bus_if.round_idx, 7'd0);
`endif
    end
    bus_if.start = 1'b1;
    bus_if.first_block = first;
    step();
    bus_if.start = 1'b0;
    bus_if.first_block = 1'b0;
    if (mode != MODE_ABORT) begin
      e.digest = digest;
      e.check_digest = check_digest;
      e.cycle = cyc + 65 + ((mode == MODE_STALL) ? 9 : 0);
      exp_q.push_back(e);
    end
    for (int r = 0; r < 64; r++) begin
      if (mode == MODE_ABORT && r == 40) begin
        abort_block();
        return;
      end
      bus_if.w = wsched[r];
      bus_if.w_valid = 1'b1;
      if (mode == MODE_IGNORE && (r == 10 || r == 50)) bus_if.start = 1'b1;
`ifdef SHA_256_ROUND_TRACE_EN
      if (mode == MODE_IGNORE && (r == 10 || r == 63)) chk("trace_round", bus_if.round_idx, 7'(r));
`endif
      step();
      bus_if.start = 1'b0;
      if (mode == MODE_STALL && (r == 0 || r == 31 || r == 62)) begin
        bus_if.w_valid = 1'b0;
        bus_if.w = 32'hffffffff;
        repeat (3) begin
          chk("busy_stall", bus_if.busy, 1'b1);
          step();
        end
      end
    end
    // Extra words offered in FINAL and IDLE must be dropped
    if (mode == MODE_IGNORE) bus_if.w = 32'h0badf00d;
    else bus_if.w_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus_if.hash_valid) seen = 1'b1;
      else step();
    end
    chk("hash_valid_timeout", seen, 1'b1);
    step();
    bus_if.w_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every hash_valid and checks digest hold otherwise
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus_if.hash_valid) begin
        chk("hash_valid_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("hash_valid_cycle", cyc, e.cycle);
          if (e.check_digest) chk("digest", bus_if.hash_out, e.digest);
          chk("busy_at_hash_valid", bus_if.busy, 1'b0);
        end
      end else begin
        chk("hash_out_hold", bus_if.hash_out, prev_hash);
      end
    end
    prev_hash = bus_if.hash_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.first_block = 1'b0;
    bus_if.w_valid = 1'b0;
    bus_if.w = 32'h0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus_if.busy, 1'b0);
    chk("reset_hash_valid", bus_if.hash_valid, 1'b0);
    chk("reset_hash_out", bus_if.hash_out, 256'h0);
`ifdef SHA_256_ROUND_TRACE_EN
    chk("reset_round_idx", bus_if.round_idx, 7'd0);
    chk("reset_round_done", bus_if.round_done, 1'b0);
`endif
    rst = 1'b1;
    step();

    run_block(BLK_ABC,   1'b1, DIG_ABC,   1'b1, MODE_PLAIN);
    run_block(BLK_EMPTY, 1'b1, DIG_EMPTY, 1'b1, MODE_PLAIN);
    run_block(BLK_TWO1,  1'b1, 256'h0,    1'b0, MODE_PLAIN);
    run_block(BLK_TWO2,  1'b0, DIG_TWO,   1'b1, MODE_PLAIN);
    run_block(BLK_ABC,   1'b1, DIG_ABC,   1'b1, MODE_STALL);
    run_block(BLK_ABC,   1'b1, DIG_ABC,   1'b1, MODE_ABORT);
    run_block(BLK_ABC,   1'b1, DIG_ABC,   1'b1, MODE_PLAIN);
    run_block(BLK_ABC,   1'b1, DIG_ABC,   1'b1, MODE_IGNORE);

    repeat (4) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_256_compression_core.md
Name: sha_256_compression_core

Overview:
Downstream neighbour of the SHA-256 message scheduler. It consumes the 64 scheduled words W[0..63], one per accepted cycle, and runs the 64 SHA-256 compression rounds on working variables a..h. At the end of a block it adds the result into the 256-bit chaining value. Multi-block messages chain automatically, and the final digest is presented on hash_out with a one-cycle hash_valid pulse.

Parameters:
NUM_ROUNDS, 64, rounds per block. Must be 64 for SHA-256 compliance; other values are allowed for bring-up only, with K indexed modulo 64.

Ports:
clk         input   1    rising-edge clock
rst         input   1    reset, asynchronous, active-low
start       input   1    begin a block; sampled only in IDLE
first_block input   1    sampled with start; 1 = load IV into H, 0 = keep previous H
w_valid     input   1    w carries the next scheduled word this cycle
w           input   32   scheduled word W[round], MSW-first order
busy        output  1    high from start acceptance until hash_valid
hash_valid  output  1    one-cycle pulse when hash_out is updated
hash_out    output  256  H0..H7, H0 in bits [255:224]

Behaviour:
- Reset (rst=0, async): state=IDLE, round=0, a..h=0, H0..H7=0, hash_out=0, busy=0, hash_valid=0.
- States: IDLE, ROUNDS, FINAL.
- IDLE -> ROUNDS when start=1.
  - first_block=1: H <= IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) and a..h <= IV.
  - first_block=0: a..h <= current H.
  - round <= 0; busy <= 1 the next cycle.
- w_valid in IDLE is ignored. start while not IDLE is ignored.
- ROUNDS: each cycle with w_valid=1:
  - T1 = h + S1(e) + Ch(e,f,g) + K[round] + w
  - T2 = S0(a) + Maj(a,b,c)
  - h<=g; g<=f; f<=e; e<=d+T1; d<=c; c<=b; b<=a; a<=T1+T2; round<=round+1
  - S0 = ROTR2^ROTR13^ROTR22. S1 = ROTR6^ROTR11^ROTR25. Ch = (e&f)^(~e&g). Maj = (a&b)^(a&c)^(b&c).
  - All additions are mod 2^32, carries discarded.
- w_valid=0 in ROUNDS: stall; all state holds. No timeout.
- ROUNDS -> FINAL on the cycle that consumes the word with round=NUM_ROUNDS-1.
- FINAL, one cycle:
  - Hi <= Hi + working var i (mod 2^32).
  - hash_out <= the new H; hash_valid=1 for exactly this edge's following cycle.
  - busy <= 0; state -> IDLE.
- start is accepted in the IDLE cycle directly after hash_valid. Back-to-back blocks therefore cost NUM_ROUNDS+2 cycles minimum.
- Latency: start edge, then 64 w_valid cycles, then 1 cycle; hash_valid asserts 1 cycle after the 64th word is consumed.
- hash_out holds its value until the next FINAL or reset. It does not change during rounds.
- K[0..63] is a 64x32 constant ROM (FIPS 180-4), selected combinationally by round[5:0].
- w_valid high during the FINAL cycle: the word is dropped. The upstream must not present words beyond 64 per block.
- Reset mid-block: abandons the block immediately. No hash_valid. H is cleared, so the next block must use first_block=1.

Optional Feature:
SHA_256_ROUND_TRACE_EN
- Defined: adds output round_idx[6:0] (current round counter, 0 in IDLE) and output round_done (1 on each cycle a word is consumed). Both are reset to 0.
- Undefined: neither port nor its logic exists; core behaviour is identical.

Test Plan:
- "abc" single block: start+first_block=1, then W from scheduler (W0=61626380, W15=00000018, rest derived), w_valid continuous -> hash_valid 66 cycles after start; hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: W0=80000000, W1..15=0 -> hash_out=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with first_block=1, block 2 with first_block=0 started the cycle after the first hash_valid -> final hash_out=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; the intermediate hash_valid also pulses once.
- Stalls: "abc" with w_valid dropped for 3 cycles after rounds 0, 31 and 62 -> same digest; hash_valid 9 cycles later than the unstalled run; busy stays 1 throughout.
- Reset mid-block: assert rst=0 at round 40 -> next cycle busy=0, hash_out=0, no hash_valid. A new "abc" run after release gives the correct digest.
- Ignored inputs: start pulses at rounds 10 and 50 plus w_valid in IDLE -> no effect on round count or digest; with SHA_256_ROUND_TRACE_EN, round_idx reads 0, 10, 63 at the corresponding points.
